// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment readback path: segment bit positions,
// the active-low glyph patterns, and the glitch-filter state encoding.
package seg7_pkg;

    localparam int unsigned SegTop      = 0;
    localparam int unsigned SegRightTop = 1;
    localparam int unsigned SegRightBot = 2;
    localparam int unsigned SegBottom   = 3;
    localparam int unsigned SegLeftBot  = 4;
    localparam int unsigned SegLeftTop  = 5;
    localparam int unsigned SegMiddle   = 6;

    localparam logic [6:0] Pat0     = 7'h40;
    localparam logic [6:0] Pat1     = 7'h79;
    localparam logic [6:0] Pat2     = 7'h24;
    localparam logic [6:0] Pat3     = 7'h30;
    localparam logic [6:0] Pat4     = 7'h19;
    localparam logic [6:0] Pat5     = 7'h12;
    localparam logic [6:0] Pat6     = 7'h02;
    localparam logic [6:0] Pat7     = 7'h78;
    localparam logic [6:0] Pat8     = 7'h00;
    localparam logic [6:0] Pat9     = 7'h18;
    localparam logic [6:0] PatA     = 7'h08;
    localparam logic [6:0] PatB     = 7'h03;
    localparam logic [6:0] PatC     = 7'h46;
    localparam logic [6:0] PatD     = 7'h21;
    localparam logic [6:0] PatE     = 7'h06;
    localparam logic [6:0] PatF     = 7'h0E;
    localparam logic [6:0] PatBlank = 7'h7F;

    typedef enum logic [1:0] {
        StIdle,
        StTrack,
        StHeld
    } filt_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational glyph decoder: maps an active-low segment pattern to its hex
// nibble, flagging the all-off blank pattern and anything unrecognised.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] nibble_o,
    output logic       blank_o,
    output logic       illegal_o
);

    always_comb begin
        nibble_o  = 4'h0;
        blank_o   = 1'b0;
        illegal_o = 1'b0;
        unique case (seg_i)
            Pat0:     nibble_o = 4'h0;
            Pat1:     nibble_o = 4'h1;
            Pat2:     nibble_o = 4'h2;
            Pat3:     nibble_o = 4'h3;
            Pat4:     nibble_o = 4'h4;
            Pat5:     nibble_o = 4'h5;
            Pat6:     nibble_o = 4'h6;
            Pat7:     nibble_o = 4'h7;
            Pat8:     nibble_o = 4'h8;
            Pat9:     nibble_o = 4'h9;
            PatA:     nibble_o = 4'hA;
            PatB:     nibble_o = 4'hB;
            PatC:     nibble_o = 4'hC;
            PatD:     nibble_o = 4'hD;
            PatE:     nibble_o = 4'hE;
            PatF:     nibble_o = 4'hF;
            PatBlank: blank_o  = 1'b1;
            default:  illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Snoops a multiplexed active-low 7-segment bus, debounces each strobed digit
// and assembles a full frame of hex nibbles with a one-cycle valid pulse.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 8
) (
    input  logic                      iCLK,
    input  logic                      iRST_N,
    input  logic [6:0]                iSEG,
    input  logic [NUM_DIGITS-1:0]     iDIG_EN,
    input  logic                      iERR_CLR,
    output logic [4*NUM_DIGITS-1:0]   oVALUE,
    output logic [NUM_DIGITS-1:0]     oBLANK,
    output logic                      oVALID,
    output logic                      oERR
);

    localparam logic [7:0] StableCnt = 8'(STABLE_CYCLES);

    logic [6:0]              seg_s1_q, seg_s2_q;
    logic [NUM_DIGITS-1:0]   dig_s1_q, dig_s2_q;

    filt_state_e             state_q;
    logic [7:0]              cnt_q;
    logic [NUM_DIGITS-1:0]   dig_lat_q;
    logic [6:0]              seg_lat_q;

    logic [4*NUM_DIGITS-1:0] shadow_v_q, shadow_v_d;
    logic [NUM_DIGITS-1:0]   shadow_b_q, shadow_b_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    logic [4*NUM_DIGITS-1:0] value_q, value_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic                    valid_q, valid_d;
    logic                    err_q, err_d;

    logic                    dig_onehot;
    logic                    sample_same;
    logic                    commit;
    logic [3:0]              dec_nibble;
    logic                    dec_blank;
    logic                    dec_illegal;

    // Two-flop synchronizer; idles at "all segments off, no strobe".
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            seg_s1_q <= PatBlank;
            seg_s2_q <= PatBlank;
            dig_s1_q <= '1;
            dig_s2_q <= '1;
        end else begin
            seg_s1_q <= iSEG;
            seg_s2_q <= seg_s1_q;
            dig_s1_q <= iDIG_EN;
            dig_s2_q <= dig_s1_q;
        end
    end

    assign dig_onehot  = $onehot(~dig_s2_q);
    assign sample_same = (dig_s2_q == dig_lat_q) && (seg_s2_q == seg_lat_q);
    assign commit      = (state_q == StTrack) && dig_onehot && sample_same &&
                         (cnt_q == StableCnt - 8'd1);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q   <= StIdle;
            cnt_q     <= 8'd0;
            dig_lat_q <= '1;
            seg_lat_q <= PatBlank;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (dig_onehot) begin
                        state_q   <= StTrack;
                        cnt_q     <= 8'd1;
                        dig_lat_q <= dig_s2_q;
                        seg_lat_q <= seg_s2_q;
                    end
                end
                StTrack, StHeld: begin
                    if (!dig_onehot) begin
                        state_q <= StIdle;
                        cnt_q   <= 8'd0;
                    end else if (!sample_same) begin
                        state_q   <= StTrack;
                        cnt_q     <= 8'd1;
                        dig_lat_q <= dig_s2_q;
                        seg_lat_q <= seg_s2_q;
                    end else if (commit) begin
                        state_q <= StHeld;
                        cnt_q   <= StableCnt;
                    end else if (state_q == StTrack) begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= 8'd0;
                end
            endcase
        end
    end

    seg7_pattern_decode u_decode (
        .seg_i     (seg_lat_q),
        .nibble_o  (dec_nibble),
        .blank_o   (dec_blank),
        .illegal_o (dec_illegal)
    );

    // Frame publish reads the shadow before any same-edge commit lands in it.
    always_comb begin
        shadow_v_d = shadow_v_q;
        shadow_b_d = shadow_b_q;
        mask_d     = mask_q;
        value_d    = value_q;
        blank_d    = blank_q;
        valid_d    = 1'b0;
        err_d      = err_q;
        if (&mask_q) begin
            value_d = shadow_v_q;
            blank_d = shadow_b_q;
            valid_d = 1'b1;
            mask_d  = '0;
        end
        if (commit && !dec_illegal) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (!dig_lat_q[k]) begin
                    shadow_v_d[4*k +: 4] = dec_nibble;
                    shadow_b_d[k]        = dec_blank;
                    mask_d[k]            = 1'b1;
                end
            end
        end
        if (commit && dec_illegal) begin
            err_d = 1'b1;
        end else if (iERR_CLR) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            shadow_v_q <= '0;
            shadow_b_q <= '0;
            mask_q     <= '0;
            value_q    <= '0;
            blank_q    <= '1;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            shadow_v_q <= shadow_v_d;
            shadow_b_q <= shadow_b_d;
            mask_q     <= mask_d;
            value_q    <= value_d;
            blank_q    <= blank_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign oVALUE = value_q;
    assign oBLANK = blank_q;
    assign oVALID = valid_q;
    assign oERR   = err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scans checked every cycle against a
// run-length window model, plus literal frame expectations per scenario.
module tb_seg7_scan_decoder;

    localparam int unsigned ND = 4;
    localparam int unsigned SC = 8;
    localparam logic [6:0] PAT_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic              clk     = 1'b0;
    logic              rst_n   = 1'b0;
    logic [6:0]        seg     = 7'h7F;
    logic [ND-1:0]     dig     = '1;
    logic              err_clr = 1'b0;
    logic [4*ND-1:0]   o_value;
    logic [ND-1:0]     o_blank;
    logic              o_valid;
    logic              o_err;

    int tests  = 0;
    int fails  = 0;
    int vcount = 0;

    // Model state
    logic [ND+6:0]     pipe0 = '1, pipe1 = '1;
    logic [ND+6:0]     hist[$];
    logic [4*ND-1:0]   m_sv = '0;
    logic [ND-1:0]     m_sb = '0, m_mask = '0;
    logic [4*ND-1:0]   m_value = '0;
    logic [ND-1:0]     m_blank = '1;
    logic              m_valid = 1'b0, m_err = 1'b0;

    always #5 clk = ~clk;

    seg7_scan_decoder #(
        .NUM_DIGITS    (ND),
        .STABLE_CYCLES (SC)
    ) dut (
        .iCLK     (clk),
        .iRST_N   (rst_n),
        .iSEG     (seg),
        .iDIG_EN  (dig),
        .iERR_CLR (err_clr),
        .oVALUE   (o_value),
        .oBLANK   (o_blank),
        .oVALID   (o_valid),
        .oERR     (o_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void decode(input logic [6:0] p, output logic [3:0] nib,
                                   output logic blank, output logic illegal);
        nib     = 4'h0;
        blank   = (p == 7'h7F);
        illegal = !blank;
        for (int i = 0; i < 16; i++) begin
            if (PAT_TAB[i] == p) begin
                nib     = 4'(i);
                illegal = 1'b0;
            end
        end
    endfunction

    // A digit is accepted when the last SC delayed samples are one identical
    // one-hot strobe/pattern pair and the sample before them was different.
    task automatic model_step();
        logic [ND+6:0] s;
        logic          commit;
        logic [3:0]    nib;
        logic          bl, il;
        if (!rst_n) begin
            pipe0 = '1; pipe1 = '1;
            hist.delete();
            m_sv = '0; m_sb = '0; m_mask = '0;
            m_value = '0; m_blank = '1; m_valid = 1'b0; m_err = 1'b0;
            return;
        end
        s     = pipe1;
        pipe1 = pipe0;
        pipe0 = {dig, seg};
        hist.push_back(s);
        if (hist.size() > int'(SC) + 1) void'(hist.pop_front());
        commit = ($countones(~s[ND+6:7]) == 1) && (hist.size() >= int'(SC));
        if (commit) begin
            for (int i = 0; i < int'(SC); i++)
                if (hist[hist.size()-1-i] != s) commit = 1'b0;
            if (hist.size() == int'(SC) + 1 && hist[0] == s) commit = 1'b0;
        end
        if (m_mask == '1) begin
            m_value = m_sv; m_blank = m_sb; m_valid = 1'b1; m_mask = '0;
        end else begin
            m_valid = 1'b0;
        end
        nib = 4'h0; bl = 1'b0; il = 1'b0;
        if (commit) begin
            decode(s[6:0], nib, bl, il);
            if (!il) begin
                for (int k = 0; k < int'(ND); k++) begin
                    if (!s[7+k]) begin
                        m_sv[4*k +: 4] = nib;
                        m_sb[k]        = bl;
                        m_mask[k]      = 1'b1;
                    end
                end
            end
        end
        if (commit && il) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            check("value", 32'(o_value), 32'(m_value));
            check("blank", 32'(o_blank), 32'(m_blank));
            check("valid", 32'(o_valid), 32'(m_valid));
            check("err",   32'(o_err),   32'(m_err));
            if (o_valid) vcount++;
        end
    end

    task automatic drive_digit(input int k, input logic [6:0] p, input int hold);
        dig = ~(ND'(1) << k);
        seg = p;
        repeat (hold) @(negedge clk);
    endtask

    task automatic idle(input int n);
        dig = '1;
        seg = 7'h7F;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan4(input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2,
                         input logic [6:0] p3, input int hold);
        drive_digit(0, p0, hold);
        drive_digit(1, p1, hold);
        drive_digit(2, p2, hold);
        drive_digit(3, p3, hold);
        idle(6);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_value", 32'(o_value), 32'h0);
        check("rst_blank", 32'(o_blank), 32'hF);
        check("rst_valid", 32'(o_valid), 32'h0);
        check("rst_err",   32'(o_err),   32'h0);
        rst_n = 1'b1;
        idle(4);

        vcount = 0;
        scan4(7'h79, 7'h24, 7'h30, 7'h19, 20);
        check("t1_vcount", 32'(vcount), 32'd1);
        check("t1_value",  32'(o_value), 32'h4321);
        check("t1_blank",  32'(o_blank), 32'h0);
        check("t1_err",    32'(o_err),   32'h0);

        vcount = 0;
        scan4(7'h79, 7'h24, 7'h30, 7'h19, 7);
        check("t2_vcount", 32'(vcount), 32'd0);
        check("t2_value",  32'(o_value), 32'h4321);

        vcount = 0;
        scan4(7'h40, 7'h40, 7'h7F, 7'h40, 20);
        check("t3_vcount", 32'(vcount), 32'd1);
        check("t3_value",  32'(o_value), 32'h0000);
        check("t3_blank",  32'(o_blank), 32'h4);

        vcount = 0;
        scan4(7'h40, 7'h55, 7'h40, 7'h40, 20);
        check("t4_err_set", 32'(o_err), 32'h1);
        check("t4_vcount0", 32'(vcount), 32'd0);
        // Clear lands on the same edge as the second illegal commit.
        dig = ~(ND'(1) << 1);
        seg = 7'h55;
        repeat (9) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        repeat (12) @(negedge clk);
        idle(6);
        check("t4_err_held", 32'(o_err), 32'h1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        check("t4_err_clr", 32'(o_err), 32'h0);
        drive_digit(1, 7'h79, 20);
        idle(6);
        check("t4_vcount1", 32'(vcount), 32'd1);
        check("t4_value",   32'(o_value), 32'h0010);
        check("t4_blank",   32'(o_blank), 32'h0);

        vcount = 0;
        dig = 4'b0011;
        seg = 7'h40;
        repeat (50) @(negedge clk);
        idle(6);
        check("t5_vcount", 32'(vcount), 32'd0);
        check("t5_err",    32'(o_err),  32'h0);

        drive_digit(0, 7'h08, 20);
        drive_digit(1, 7'h03, 20);
        drive_digit(2, 7'h46, 20);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_rst_value", 32'(o_value), 32'h0);
        check("t6_rst_blank", 32'(o_blank), 32'hF);
        rst_n = 1'b1;
        idle(4);
        vcount = 0;
        drive_digit(3, 7'h21, 20);
        idle(6);
        check("t6_partial_vcount", 32'(vcount), 32'd0);
        scan4(7'h08, 7'h03, 7'h46, 7'h21, 20);
        check("t6_vcount", 32'(vcount), 32'd1);
        check("t6_value",  32'(o_value), 32'hDCBA);
        check("t6_blank",  32'(o_blank), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Display-readback block: samples a multiplexed, active-low 7-segment bus (segment lines plus active-low digit strobes), filters out scan-transition glitches, and decodes each stable pattern back to its hex nibble. Assembles one frame of NUM_DIGITS nibbles and presents it with a one-cycle valid strobe. Sits beside the display driver path and is used for self-check and for snooping external display boards.

## Interface
- NUM_DIGITS, 4: number of multiplexed digits; range 1–8.
- STABLE_CYCLES, 8: consecutive identical samples required to accept a digit; range 2–255.
- iCLK  in  1  system clock.
- iRST_N  in  1  asynchronous, active-low reset.
- iSEG  in  7  active-low segment lines; bit0 = top, bit1 = right-top, bit2 = right-bottom, bit3 = bottom, bit4 = left-bottom, bit5 = left-top, bit6 = middle.
- iDIG_EN  in  NUM_DIGITS  active-low digit strobes; exactly one low = that digit is driven.
- iERR_CLR  in  1  clears oERR.
- oVALUE  out  4*NUM_DIGITS  last complete frame; digit k in bits [4k+3:4k].
- oBLANK  out  NUM_DIGITS  per digit, 1 = digit was blank (iSEG = 7'h7F) in last frame.
- oVALID  out  1  one-cycle pulse when oVALUE/oBLANK update.
- oERR  out  1  sticky: an accepted pattern was not a legal code.

## Operation
- Decode table (iSEG to nibble): 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 18→9, 08→A, 03→b, 46→C, 21→d, 06→E, 0E→F. 7F = blank (nibble 0, blank bit 1). Any other pattern is illegal.
- Inputs iSEG and iDIG_EN pass through a two-flop synchronizer; all logic below uses synchronized values.
- Filter FSM, states IDLE, TRACK, HELD:
  - IDLE: no strobe low or more than one low. Counter = 0. On exactly one low → TRACK, counter = 1, latch {digit, pattern}.
  - TRACK: sample equal to latched {digit, pattern} → counter += 1; on reaching STABLE_CYCLES, commit → HELD. Sample differs but still one-hot → restart TRACK with new latch, counter = 1. Not one-hot → IDLE.
  - HELD: sample equal → stay, no further commit. Any change → as TRACK-restart or IDLE per the rules above.
- Commit: legal/blank pattern writes nibble and blank bit into shadow slot k and sets mask bit k; re-commit of a slot in the same frame overwrites it. Illegal pattern sets oERR, slot and mask unchanged.
- Frame: when mask becomes all ones, next cycle copy shadow to oVALUE/oBLANK, pulse oVALID, clear mask.
- oERR: set on illegal commit, cleared by iERR_CLR; simultaneous set and clear → set wins.

## Timing
- Reset values: oVALUE = 0, oBLANK = all ones, oVALID = 0, oERR = 0; FSM IDLE, counter 0, mask 0, shadow 0, synchronizer flops = all ones (inactive).
- Input to FSM latency: 2 cycles.
- Commit occurs on the STABLE_CYCLES-th consecutive identical synchronized sample.
- oVALID asserts 1 cycle after the commit that completes the mask; oVALUE stable until next oVALID.
- NUM_DIGITS = 1: every legal commit produces oVALID.
- Reset mid-frame discards partial shadow and mask; no oVALID until a full new frame.
- Counter saturates at STABLE_CYCLES; it never wraps.

## Structure
- Shared package seg7_pkg: segment-bit index constants, the 16 pattern constants, BLANK pattern 7'h7F, FSM state enum.
- Sub-module seg7_pattern_decode: combinational, iSEG → {nibble, blank, illegal}; instantiated once on the latched pattern.
- Top holds synchronizer, FSM, counter, shadow/mask, output registers, error flag.

## Test plan
- Scan digits 0..3 with patterns 79, 24, 30, 19, each held 20 cycles → one oVALID, oVALUE = 16'h4321, oBLANK = 0, oERR = 0.
- Same scan, each digit held only 7 cycles (STABLE_CYCLES = 8) → no oVALID ever.
- Digit 2 driven 7F, others 40 → oVALUE = 16'h0000, oBLANK = 4'b0100.
- Digit 1 driven 7'h55 (illegal) for 20 cycles → oERR = 1, no oVALID until digit 1 later shows a legal code; assert iERR_CLR on the same cycle as a second illegal commit → oERR remains 1.
- iDIG_EN = 4'b0011 (two strobes low) with stable legal iSEG for 50 cycles → no commit, FSM stays IDLE.
- Deassert iRST_N after three digits committed, then a full scan of 08, 03, 46, 21 → exactly one oVALID, oVALUE = 16'hDCBA.
